// File: rtl/alu_commit.sv
// Commit stage: owns accum and Z/C/GIE flags, drives the register-file write port, squashes after a taken skip.
// Optional FLAG_SHADOW_EN adds irq_enter/irq_return with a shadow copy of {accum, z, c}.
module alu_commit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              accum_write,
    input  logic              reg_write,
    input  logic              z_write,
    input  logic              zout,
    input  logic              c_write,
    input  logic              cout,
    input  logic              gie_write,
    input  logic              gieout,
    input  logic              skip,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ack,
    output logic [DATA_W-1:0] accum,
    output logic              z_flag,
    output logic              c_flag,
    output logic              gie,
`ifdef FLAG_SHADOW_EN
    input  logic              irq_enter,
    input  logic              irq_return,
`endif
    output logic              squash
);

    typedef enum logic {RUN, WAIT_RF} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] accum_q, accum_d;
    logic              z_q, z_d, c_q, c_d, gie_q, gie_d;
    logic              skip_pending_q, skip_pending_d;
    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              squash_q, squash_d;
    logic              accept;

`ifdef FLAG_SHADOW_EN
    logic [DATA_W-1:0] s_accum_q, s_accum_d;
    logic              s_z_q, s_z_d, s_c_q, s_c_d;

    assign in_ready = (state_q == RUN) && !irq_enter && !irq_return;
`else
    assign in_ready = (state_q == RUN);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        accum_d        = accum_q;
        z_d            = z_q;
        c_d            = c_q;
        gie_d          = gie_q;
        skip_pending_d = skip_pending_q;
        rf_wen_d       = rf_wen_q;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        squash_d       = 1'b0;
`ifdef FLAG_SHADOW_EN
        s_accum_d      = s_accum_q;
        s_z_d          = s_z_q;
        s_c_d          = s_c_q;
`endif
        if (state_q == RUN) begin
`ifdef FLAG_SHADOW_EN
            // Interrupt strobes hold off acceptance, so they never coincide with a commit.
            if (irq_enter) begin
                s_accum_d      = accum_q;
                s_z_d          = z_q;
                s_c_d          = c_q;
                gie_d          = 1'b0;
                skip_pending_d = 1'b0;
            end else if (irq_return) begin
                accum_d = s_accum_q;
                z_d     = s_z_q;
                c_d     = s_c_q;
                gie_d   = 1'b1;
            end else
`endif
            if (accept) begin
                if (skip_pending_q) begin
                    // Discarded instruction: its own skip is ignored too.
                    skip_pending_d = 1'b0;
                    squash_d       = 1'b1;
                end else begin
                    if (accum_write) accum_d = result;
                    if (z_write)     z_d     = zout;
                    if (c_write)     c_d     = cout;
                    if (gie_write)   gie_d   = gieout;
                    skip_pending_d = skip;
                    if (reg_write) begin
                        rf_wen_d   = 1'b1;
                        rf_waddr_d = dest_addr;
                        rf_wdata_d = result;
                        state_d    = WAIT_RF;
                    end
                end
            end
        end else if (rf_ack) begin
            rf_wen_d = 1'b0;
            state_d  = RUN;
        end
    end

    // NOTE: state uses non-blocking assignments only; next-state values come from always_comb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            accum_q        <= '0;
            z_q            <= 1'b0;
            c_q            <= 1'b0;
            gie_q          <= 1'b0;
            skip_pending_q <= 1'b0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            squash_q       <= 1'b0;
`ifdef FLAG_SHADOW_EN
            s_accum_q      <= '0;
            s_z_q          <= 1'b0;
            s_c_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            accum_q        <= accum_d;
            z_q            <= z_d;
            c_q            <= c_d;
            gie_q          <= gie_d;
            skip_pending_q <= skip_pending_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            squash_q       <= squash_d;
`ifdef FLAG_SHADOW_EN
            s_accum_q      <= s_accum_d;
            s_z_q          <= s_z_d;
            s_c_q          <= s_c_d;
`endif
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign accum    = accum_q;
    assign z_flag   = z_q;
    assign c_flag   = c_q;
    assign gie      = gie_q;
    assign squash   = squash_q;

endmodule

// File: tb/tb_alu_commit.sv
// Directed self-checking bench for alu_commit; FLAG_SHADOW_EN adds the interrupt shadow scenario.
module tb_alu_commit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [7:0] result, dest_addr;
    logic       accum_write, reg_write, z_write, zout, c_write, cout, gie_write, gieout, skip;
    logic       rf_wen, rf_ack;
    logic [7:0] rf_waddr, rf_wdata, accum;
    logic       z_flag, c_flag, gie, squash;
`ifdef FLAG_SHADOW_EN
    logic       irq_enter, irq_return;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_commit #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .dest_addr(dest_addr),
        .accum_write(accum_write), .reg_write(reg_write),
        .z_write(z_write), .zout(zout), .c_write(c_write), .cout(cout),
        .gie_write(gie_write), .gieout(gieout), .skip(skip),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
        .accum(accum), .z_flag(z_flag), .c_flag(c_flag), .gie(gie),
`ifdef FLAG_SHADOW_EN
        .irq_enter(irq_enter), .irq_return(irq_return),
`endif
        .squash(squash)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; result = '0; dest_addr = '0;
        accum_write = 0; reg_write = 0; z_write = 0; zout = 0;
        c_write = 0; cout = 0; gie_write = 0; gieout = 0; skip = 0; rf_ack = 0;
`ifdef FLAG_SHADOW_EN
        irq_enter = 0; irq_return = 0;
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #12;
        // 1. reset state
        check("rst_accum", accum, 8'h00);
        check("rst_z", z_flag, 0);
        check("rst_c", c_flag, 0);
        check("rst_gie", gie, 0);
        check("rst_rf_wen", rf_wen, 0);
        check("rst_squash", squash, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 0;

        // 2. accum load with Z write
        in_valid = 1; result = 8'h5A; accum_write = 1; z_write = 1; zout = 0;
        cycle();
        idle_inputs();
        check("t2_accum", accum, 8'h5A);
        check("t2_z", z_flag, 0);
        check("t2_rf_wen", rf_wen, 0);

        // 3. register write held across 3 cycles of no ack; a pending result must not be taken
        in_valid = 1; reg_write = 1; dest_addr = 8'h12; result = 8'h80;
        cycle();
        idle_inputs();
        in_valid = 1; accum_write = 1; result = 8'h77;
        for (int i = 0; i < 3; i++) begin
            check("t3_rf_wen", rf_wen, 1);
            check("t3_addr", rf_waddr, 8'h12);
            check("t3_data", rf_wdata, 8'h80);
            check("t3_in_ready", in_ready, 0);
            cycle();
        end
        idle_inputs();
        rf_ack = 1;
        check("t3_ready_on_ack", in_ready, 0);
        cycle();
        rf_ack = 0;
        check("t3_rf_wen_off", rf_wen, 0);
        check("t3_in_ready_on", in_ready, 1);
        check("t3_accum_kept", accum, 8'h5A);

        // 4. skip squashes the next accept (whose own skip is ignored), third accept lands
        in_valid = 1; skip = 1;
        cycle();
        check("t4_no_squash_skipper", squash, 0);
        skip = 1; accum_write = 1; result = 8'hFF;
        cycle();
        check("t4_squash", squash, 1);
        check("t4_accum_unchanged", accum, 8'h5A);
        skip = 0; result = 8'h01;
        cycle();
        idle_inputs();
        check("t4_accum_third", accum, 8'h01);
        check("t4_squash_clear", squash, 0);

        // 5. flags update immediately while the register write is still pending
        in_valid = 1; c_write = 1; cout = 1; gie_write = 1; gieout = 1;
        reg_write = 1; dest_addr = 8'h34; result = 8'h99;
        cycle();
        idle_inputs();
        check("t5_c", c_flag, 1);
        check("t5_gie", gie, 1);
        check("t5_rf_wen", rf_wen, 1);
        check("t5_addr", rf_waddr, 8'h34);
        check("t5_accum_kept", accum, 8'h01);
        rf_ack = 1;
        cycle();
        rf_ack = 0;
        check("t5_rf_wen_off", rf_wen, 0);

        // Z set to one, plus accum and register write on one instruction
        in_valid = 1; z_write = 1; zout = 1; accum_write = 1; reg_write = 1;
        dest_addr = 8'h03; result = 8'hC3;
        cycle();
        idle_inputs();
        check("zc_z", z_flag, 1);
        check("zc_accum", accum, 8'hC3);
        check("zc_data", rf_wdata, 8'hC3);
        rf_ack = 1;
        cycle();
        rf_ack = 0;

`ifdef FLAG_SHADOW_EN
        // 6. interrupt shadow save and restore
        in_valid = 1; accum_write = 1; result = 8'h33; z_write = 1; zout = 1;
        cycle();
        idle_inputs();
        irq_enter = 1;
        #1 check("t6_ready_irq", in_ready, 0);
        cycle();
        idle_inputs();
        check("t6_gie_cleared", gie, 0);
        in_valid = 1; accum_write = 1; result = 8'h44; z_write = 1; zout = 0;
        cycle();
        idle_inputs();
        check("t6_accum_44", accum, 8'h44);
        irq_return = 1;
        cycle();
        idle_inputs();
        check("t6_accum_restored", accum, 8'h33);
        check("t6_z_restored", z_flag, 1);
        check("t6_gie_set", gie, 1);
`endif

        // reset during WAIT_RF drops rf_wen without waiting for a clock
        in_valid = 1; reg_write = 1; dest_addr = 8'h55; result = 8'hAA; c_write = 1; cout = 1;
        cycle();
        idle_inputs();
        check("rm_rf_wen", rf_wen, 1);
        #2 reset = 1;
        #1;
        check("rm_rf_wen_off", rf_wen, 0);
        check("rm_accum", accum, 8'h00);
        check("rm_c", c_flag, 0);
        check("rm_in_ready", in_ready, 1);
        #1 reset = 0;
        cycle();
        check("rm_stays_idle", rf_wen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
